alloc_req_arbiter: RTL and testbench
====================================

Name: alloc_req_arbiter

Overview:
Shares the single falafel allocator core between NUM_CLIENTS requesters issuing alloc and free operations. Accepts one request at a time using round-robin arbitration and forwards it to the core over a valid/ready handshake. It then waits for the core's completion and returns the result to the granted client only. A watchdog converts a hung core operation into an error response so clients never deadlock. Sits between client ports (e.g. per-hart shims) and the core's request/response interface.

Parameters:
NUM_CLIENTS, 4, number of requesters (2..16)
DATA_W, falafel_pkg::DATA_W, width of size/address fields
TIMEOUT_CYCLES, 256, max cycles waiting for a core response (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
client_req_valid_i  in  NUM_CLIENTS  per-client request valid
client_req_is_alloc_i  in  NUM_CLIENTS  1=alloc, 0=free
client_req_data_i  in  NUM_CLIENTS*DATA_W  alloc size or free address; client k uses slice [k*DATA_W +: DATA_W]
client_req_ready_o  out  NUM_CLIENTS  one-hot accept strobe
client_rsp_valid_o  out  NUM_CLIENTS  one-hot response valid
client_rsp_ready_i  in  NUM_CLIENTS  per-client response ready
client_rsp_addr_o  out  DATA_W  allocated address (0 for free/fail), shared bus
client_rsp_success_o  out  1  operation succeeded
client_rsp_timeout_o  out  1  response produced by watchdog
core_req_valid_o  out  1  request to core
core_req_is_alloc_o  out  1  op to core
core_req_data_o  out  DATA_W  size/address to core
core_ready_i  in  1  core accepts request
core_rsp_valid_i  in  1  core completion pulse
core_rsp_addr_i  in  DATA_W  core result address
core_rsp_success_i  in  1  core result status
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, rr_ptr=0, timer=0, all latched fields 0; every output 0.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESPOND.
- IDLE: if any client_req_valid_i, grant the first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_CLIENTS. Same cycle: client_req_ready_o[g]=1 (combinational from valid and rr_ptr, exactly one bit), latch g/is_alloc/data, rr_ptr<=(g+1) mod NUM_CLIENTS, go ISSUE. No valid: stay.
- ISSUE: core_req_valid_o=1 with latched op/data, held stable until core_ready_i. Handshake cycle: timer<=0, go WAIT_RSP. Earliest core_req_valid_o is 1 cycle after accept.
- WAIT_RSP: core_rsp_valid_i -> latch addr/success, timeout=0, go RESPOND. Otherwise timer++. If timer==TIMEOUT_CYCLES-1 with no rsp: latch addr=0, success=0, timeout=1, go RESPOND. A core rsp coinciding with the expiry cycle wins (real result, timeout=0).
- RESPOND: client_rsp_valid_o[g]=1 (one-hot). Addr/success/timeout held stable until client_rsp_ready_i[g]=1; then go IDLE. Other clients' ready bits ignored.
- core_rsp_valid_i outside WAIT_RSP (late or spurious) is ignored; no state change.
- Free ops: latched core addr is forwarded as-is. Clients are told to disregard addr for frees.
- Only one outstanding core operation ever; no new grant until RESPOND completes. The minimum request-to-request period is 4 cycles.
- A client may drop valid while not granted. Data is sampled only in the grant cycle.
- Reset mid-operation: immediate return to IDLE, outputs 0, in-flight op lost; core is reset by the same rst_ni.
- Widths: timer is $clog2(TIMEOUT_CYCLES) bits, rr_ptr $clog2(NUM_CLIENTS) bits. Wrap is explicit mod NUM_CLIENTS, correct for non-power-of-2 counts.

Test Plan:
- Client 2 alloc size 0x40; core_ready_i=1 at once; rsp addr 0x1000 success 1 three cycles later -> client_req_ready_o=4'b0100 for 1 cycle, core_req_data_o=0x40, client_rsp_valid_o=4'b0100 with addr 0x1000, success 1, timeout 0.
- All 4 clients valid continuously from reset, core answers in 2 cycles -> grant order 0,1,2,3,0; never two ready bits set; busy_o drops 1 cycle between ops.
- Client 1 free, data 0x2000 -> core_req_is_alloc_o=0, core_req_data_o=0x2000; core_ready_i held low 5 cycles -> request fields stable throughout.
- TIMEOUT_CYCLES=16, no core rsp -> RESPOND entered 16 cycles after first WAIT_RSP cycle: success 0, timeout 1, addr 0. Late core_rsp_valid_i in IDLE ignored.
- client_rsp_ready_i low 5 cycles during RESPOND while other clients valid -> response held stable, no client_req_ready_o asserted until handshake.
- rst_ni pulsed low during WAIT_RSP -> all outputs 0 same cycle. After release, client 3 alone valid is granted first (rr_ptr=0, search reaches 3).

Source files
------------

// File: rtl/alloc_req_arbiter.sv
// rtl/alloc_req_arbiter.sv - round-robin arbiter sharing the falafel allocator core between clients
//
// Purpose: accepts one alloc/free request at a time from NUM_CLIENTS requesters,
// forwards it to the allocator core, waits for completion (bounded by a watchdog)
// and returns the result to the granted client only.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   client_req_valid_i [N]        per-client request valid
//   client_req_is_alloc_i [N]     1 = alloc, 0 = free
//   client_req_data_i [N*DATA_W]  alloc size / free address, client k at [k*DATA_W +: DATA_W]
//   client_req_ready_o [N]        one-hot accept strobe (combinational, IDLE only)
//   client_rsp_valid_o [N]        one-hot response valid
//   client_rsp_ready_i [N]        per-client response ready
//   client_rsp_addr_o             result address (shared bus)
//   client_rsp_success_o          operation succeeded
//   client_rsp_timeout_o          response was produced by the watchdog
//   core_req_valid_o/is_alloc_o/data_o, core_ready_i   request handshake to the core
//   core_rsp_valid_i/addr_i/success_i                  core completion pulse
//   busy_o                        an operation is in flight (not IDLE)

package falafel_pkg;
    parameter int DATA_W = 32;
endpackage

module alloc_req_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int DATA_W         = falafel_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_CLIENTS-1:0]        client_req_valid_i,
    input  logic [NUM_CLIENTS-1:0]        client_req_is_alloc_i,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_req_data_i,
    output logic [NUM_CLIENTS-1:0]        client_req_ready_o,
    output logic [NUM_CLIENTS-1:0]        client_rsp_valid_o,
    input  logic [NUM_CLIENTS-1:0]        client_rsp_ready_i,
    output logic [DATA_W-1:0]             client_rsp_addr_o,
    output logic                          client_rsp_success_o,
    output logic                          client_rsp_timeout_o,
    output logic                          core_req_valid_o,
    output logic                          core_req_is_alloc_o,
    output logic [DATA_W-1:0]             core_req_data_o,
    input  logic                          core_ready_i,
    input  logic                          core_rsp_valid_i,
    input  logic [DATA_W-1:0]             core_rsp_addr_i,
    input  logic                          core_rsp_success_i,
    output logic                          busy_o
);

    localparam int PTR_W = $clog2(NUM_CLIENTS);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_RESPOND
    } state_e;

    state_e                   state_q;
    logic [PTR_W-1:0]         rr_ptr_q;
    logic [TMR_W-1:0]         timer_q;
    logic [PTR_W-1:0]         gnt_q;
    logic                     op_is_alloc_q;
    logic [DATA_W-1:0]        op_data_q;
    logic [DATA_W-1:0]        rsp_addr_q;
    logic                     rsp_success_q;
    logic                     rsp_timeout_q;
    logic                     core_req_valid_q;
    logic [NUM_CLIENTS-1:0]   rsp_valid_q;
    logic                     busy_q;

    logic                     gnt_found;
    logic [PTR_W-1:0]         gnt_idx;
    logic [PTR_W-1:0]         rr_ptr_d;

    // Index base+off wrapped modulo NUM_CLIENTS; explicit so non-power-of-2
    // client counts never select a nonexistent client.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CLIENTS) begin
            sum = sum - NUM_CLIENTS;
        end
        return PTR_W'(sum);
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_CLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first valid client starting at rr_ptr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!gnt_found && client_req_valid_i[wrap_idx(rr_ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    assign rr_ptr_d = wrap_idx(gnt_idx, 1);

    // The accept strobe is combinational; gating with rst_ni keeps it low while
    // reset is held even if clients are already requesting.
    always_comb begin
        client_req_ready_o = '0;
        if (rst_ni && (state_q == ST_IDLE) && gnt_found) begin
            client_req_ready_o = to_onehot(gnt_idx);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            rr_ptr_q         <= '0;
            timer_q          <= '0;
            gnt_q            <= '0;
            op_is_alloc_q    <= 1'b0;
            op_data_q        <= '0;
            rsp_addr_q       <= '0;
            rsp_success_q    <= 1'b0;
            rsp_timeout_q    <= 1'b0;
            core_req_valid_q <= 1'b0;
            rsp_valid_q      <= '0;
            busy_q           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        gnt_q            <= gnt_idx;
                        op_is_alloc_q    <= client_req_is_alloc_i[gnt_idx];
                        op_data_q        <= client_req_data_i[int'(gnt_idx)*DATA_W +: DATA_W];
                        rr_ptr_q         <= rr_ptr_d;
                        core_req_valid_q <= 1'b1;
                        busy_q           <= 1'b1;
                        state_q          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (core_ready_i) begin
                        core_req_valid_q <= 1'b0;
                        timer_q          <= '0;
                        state_q          <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    // A real completion takes priority over the watchdog expiring
                    // in the same cycle.
                    if (core_rsp_valid_i) begin
                        rsp_addr_q    <= core_rsp_addr_i;
                        rsp_success_q <= core_rsp_success_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= to_onehot(gnt_q);
                        state_q       <= ST_RESPOND;
                    end else if (timer_q == TMR_LAST) begin
                        rsp_addr_q    <= '0;
                        rsp_success_q <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= to_onehot(gnt_q);
                        state_q       <= ST_RESPOND;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    // Only the granted client's ready completes the response.
                    if (client_rsp_ready_i[gnt_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign client_rsp_valid_o   = rsp_valid_q;
    assign client_rsp_addr_o    = rsp_addr_q;
    assign client_rsp_success_o = rsp_success_q;
    assign client_rsp_timeout_o = rsp_timeout_q;
    assign core_req_valid_o     = core_req_valid_q;
    assign core_req_is_alloc_o  = op_is_alloc_q;
    assign core_req_data_o      = op_data_q;
    assign busy_o               = busy_q;

endmodule

// File: tb/tb_alloc_req_arbiter.sv
// tb/tb_alloc_req_arbiter.sv - randomized self-checking bench for alloc_req_arbiter
module tb_alloc_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    client_req_valid_i;
    logic [N-1:0]    client_req_is_alloc_i;
    logic [N*DW-1:0] client_req_data_i;
    logic [N-1:0]    client_req_ready_o;
    logic [N-1:0]    client_rsp_valid_o;
    logic [N-1:0]    client_rsp_ready_i;
    logic [DW-1:0]   client_rsp_addr_o;
    logic            client_rsp_success_o;
    logic            client_rsp_timeout_o;
    logic            core_req_valid_o;
    logic            core_req_is_alloc_o;
    logic [DW-1:0]   core_req_data_o;
    logic            core_ready_i;
    logic            core_rsp_valid_i;
    logic [DW-1:0]   core_rsp_addr_i;
    logic            core_rsp_success_i;
    logic            busy_o;

    alloc_req_arbiter #(
        .NUM_CLIENTS   (N),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .client_req_valid_i   (client_req_valid_i),
        .client_req_is_alloc_i(client_req_is_alloc_i),
        .client_req_data_i    (client_req_data_i),
        .client_req_ready_o   (client_req_ready_o),
        .client_rsp_valid_o   (client_rsp_valid_o),
        .client_rsp_ready_i   (client_rsp_ready_i),
        .client_rsp_addr_o    (client_rsp_addr_o),
        .client_rsp_success_o (client_rsp_success_o),
        .client_rsp_timeout_o (client_rsp_timeout_o),
        .core_req_valid_o     (core_req_valid_o),
        .core_req_is_alloc_o  (core_req_is_alloc_o),
        .core_req_data_o      (core_req_data_o),
        .core_ready_i         (core_ready_i),
        .core_rsp_valid_i     (core_rsp_valid_i),
        .core_rsp_addr_i      (core_rsp_addr_i),
        .core_rsp_success_i   (core_rsp_success_i),
        .busy_o               (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int rr_model = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference round-robin choice: first requesting client at rr, rr+1, ... mod N.
    function automatic int pick(input logic [N-1:0] mask, input int rr);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (rr + i) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, client_req_ready_o, 0);
        check_eq({tag, "_rsp_valid"}, client_rsp_valid_o, 0);
        check_eq({tag, "_rsp_fields"}, {client_rsp_addr_o, client_rsp_success_o, client_rsp_timeout_o}, 0);
        check_eq({tag, "_core_req"}, {core_req_valid_o, core_req_is_alloc_o, core_req_data_o}, 0);
        check_eq({tag, "_busy"}, busy_o, 0);
    endtask

    // One complete operation. rsp_delay >= TO means the core never answers.
    // Called at posedge+1 with the DUT idle.
    task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0] is_alloc,
                           input logic [N*DW-1:0] data, input int core_wait,
                           input int rsp_delay, input logic [DW-1:0] core_addr,
                           input logic core_ok, input int hold, input bit idle_spur);
        int           g;
        int           last;
        logic [N-1:0] oh;
        logic [DW-1:0] exp_data, exp_addr;
        logic         exp_alloc, exp_ok, exp_to;

        g         = pick(mask, rr_model);
        oh        = '0;
        oh[g]     = 1'b1;
        exp_data  = data[g*DW +: DW];
        exp_alloc = is_alloc[g];

        client_req_valid_i    = mask;
        client_req_is_alloc_i = is_alloc;
        client_req_data_i     = data;
        #1;
        check_eq("idle_busy", busy_o, 0);
        check_eq("grant_ready", client_req_ready_o, oh);
        tick();
        rr_model = (g + 1) % N;

        // Granted client drops valid; its data lines change to prove sampling at grant.
        client_req_valid_i[g] = 1'b0;
        client_req_data_i     = rand_data();
        client_req_is_alloc_i = N'($urandom());

        for (int i = 0; i <= core_wait; i++) begin
            core_ready_i = (i == core_wait);
            #1;
            check_eq("issue_busy", busy_o, 1);
            check_eq("issue_no_ready", client_req_ready_o, 0);
            check_eq("issue_req", {core_req_valid_o, core_req_is_alloc_o, core_req_data_o},
                     {1'b1, exp_alloc, exp_data});
            tick();
        end
        core_ready_i = 1'b0;

        last = (rsp_delay < TO) ? rsp_delay : TO - 1;
        for (int k = 0; k <= last; k++) begin
            core_rsp_valid_i   = (k == rsp_delay);
            core_rsp_addr_i    = (k == rsp_delay) ? core_addr : $urandom();
            core_rsp_success_i = (k == rsp_delay) ? core_ok : 1'($urandom());
            #1;
            check_eq("wait_state", {client_rsp_valid_o, core_req_valid_o, busy_o, client_req_ready_o},
                     {N'(0), 1'b0, 1'b1, N'(0)});
            tick();
        end
        core_rsp_valid_i = 1'b0;

        if (rsp_delay < TO) begin
            exp_addr = core_addr; exp_ok = core_ok; exp_to = 1'b0;
        end else begin
            exp_addr = '0; exp_ok = 1'b0; exp_to = 1'b1;
        end

        for (int h = 0; h <= hold; h++) begin
            client_rsp_ready_i = (h == hold) ? (oh | N'($urandom())) : (N'($urandom()) & ~oh);
            client_req_valid_i = N'($urandom());
            core_rsp_valid_i   = 1'($urandom());
            core_rsp_addr_i    = $urandom();
            core_rsp_success_i = 1'($urandom());
            #1;
            check_eq("rsp_valid", client_rsp_valid_o, oh);
            check_eq("rsp_fields", {client_rsp_addr_o, client_rsp_success_o, client_rsp_timeout_o},
                     {exp_addr, exp_ok, exp_to});
            check_eq("rsp_no_ready", client_req_ready_o, 0);
            tick();
        end
        client_rsp_ready_i = '0;
        client_req_valid_i = '0;
        core_rsp_valid_i   = 1'b0;
        #1;
        check_eq("done_idle", {client_rsp_valid_o, busy_o}, 0);

        if (idle_spur) begin
            core_rsp_valid_i = 1'b1;
            core_rsp_addr_i  = $urandom();
            tick();
            core_rsp_valid_i = 1'b0;
            check_eq("spur_idle", {busy_o, client_rsp_valid_o, core_req_valid_o}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL tb_watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N*DW-1:0] d;
        int              mode, dly;

        rst_ni                = 1'b0;
        client_req_valid_i    = '1;
        client_req_is_alloc_i = '0;
        client_req_data_i     = '0;
        client_rsp_ready_i    = '0;
        core_ready_i          = 1'b0;
        core_rsp_valid_i      = 1'b0;
        core_rsp_addr_i       = '0;
        core_rsp_success_i    = 1'b0;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        rst_ni   = 1'b1;
        rr_model = 0;

        // All clients requesting back-to-back: grants 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            check_eq("rr_order_model", pick('1, rr_model), t % N);
            run_txn('1, '1, rand_data(), 0, 1, $urandom(), 1'b1, 0, 1'b0);
        end

        // Client 2 alloc of 0x40 returning 0x1000.
        d = '0; d[2*DW +: DW] = 32'h40;
        run_txn(4'b0100, 4'b0100, d, 0, 1, 32'h1000, 1'b1, 0, 1'b0);

        // Client 1 free of 0x2000 with the core stalling 5 cycles.
        d = rand_data(); d[1*DW +: DW] = 32'h2000;
        run_txn(4'b0010, 4'b0000, d, 5, 2, 32'h0, 1'b1, 0, 1'b0);

        // Watchdog expiry, then a late core response in IDLE.
        run_txn(4'b1001, 4'b1111, rand_data(), 0, TO + 3, 32'hdead, 1'b1, 0, 1'b1);

        // Core response on the expiry cycle beats the watchdog.
        run_txn(4'b0001, 4'b0001, rand_data(), 1, TO - 1, 32'hbeef, 1'b1, 0, 1'b0);

        // Response held 5 cycles with other clients requesting.
        run_txn(4'b0111, 4'b0101, rand_data(), 0, 0, 32'h3000, 1'b0, 5, 1'b0);

        for (int t = 0; t < 60; t++) begin
            mode = $urandom_range(0, 3);
            if (mode < 2)       dly = $urandom_range(0, 5);
            else if (mode == 2) dly = TO - 1;
            else                dly = TO + $urandom_range(0, 5);
            run_txn(N'($urandom_range(1, (1 << N) - 1)), N'($urandom()), rand_data(),
                    $urandom_range(0, 3), dly, $urandom(), 1'($urandom()),
                    $urandom_range(0, 4), 1'($urandom()));
        end

        // Reset in the middle of WAIT_RSP.
        client_req_valid_i = '1;
        client_req_data_i  = rand_data();
        tick();
        core_ready_i = 1'b1;
        tick();
        core_ready_i = 1'b0;
        tick();
        check_eq("pre_reset_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        rst_ni   = 1'b1;
        rr_model = 0;
        check_eq("post_reset_pick", pick(4'b1000, rr_model), 3);
        run_txn(4'b1000, 4'b1000, rand_data(), 0, 2, 32'h4000, 1'b1, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
